// File: rtl/noc_defs.sv
// ------------------------------------------------------------------
// noc_defs : shared NoC widths, dest-field macro and clog2 helper
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

`ifndef NOC_DEST
`define NOC_DEST(flit, bus, addr) flit[(bus)-1 -: (addr)]
`endif

package noc_defs;

   localparam int unsigned BUS_SIZE_DEF  = 8;
   localparam int unsigned ADDR_SIZE_DEF = 4;

   // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) begin
            r = unsigned'(i + 1);
         end
      end
      return r;
   endfunction

endpackage : noc_defs

`default_nettype wire

// File: rtl/noc_fifo.sv
// ------------------------------------------------------------------
// noc_fifo : w/r handshake FIFO, flags from registered pointers only
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module noc_fifo
   import noc_defs::*;
#(
   parameter int unsigned WIDTH = BUS_SIZE_DEF,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             a_rst_n_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             w_i,
   output logic             r_o,
   output logic [WIDTH-1:0] data_o,
   output logic             w_o,
   input  logic             r_i
);

   localparam int unsigned PTR_W = clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Extra wrap bit distinguishes full (only wrap bit differs) from empty (equal).
   assign w_full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}};
   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_push  = w_i & ~w_full;
   assign w_pop   = r_i & ~w_empty;

   assign r_o    = ~w_full;
   assign w_o    = ~w_empty;
   assign data_o = w_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: data_o is masked while empty.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
      end
   end

endmodule : noc_fifo

`default_nettype wire

// File: rtl/noc_net_iface.sv
// ------------------------------------------------------------------
// noc_net_iface : PE <-> NoC node adapter with RX address filter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module noc_net_iface
   import noc_defs::*;
#(
   parameter int unsigned BUS_SIZE   = BUS_SIZE_DEF,
   parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DEF,
   parameter int unsigned NODE_ID    = 0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_SIZE   = 16
) (
   input  logic                clk_i,
   input  logic                a_rst_n_i,
   input  logic [BUS_SIZE-1:0] pe_data_i,
   input  logic                pe_w_i,
   output logic                pe_r_o,
   output logic [BUS_SIZE-1:0] pe_data_o,
   output logic                pe_w_o,
   input  logic                pe_r_i,
   output logic [BUS_SIZE-1:0] net_data_o,
   output logic                net_w_o,
   input  logic                net_r_i,
   input  logic [BUS_SIZE-1:0] net_data_i,
   input  logic                net_w_i,
   output logic                net_r_o,
   output logic [CNT_SIZE-1:0] sent_cnt_o,
   output logic [CNT_SIZE-1:0] recv_cnt_o,
   output logic [CNT_SIZE-1:0] drop_cnt_o,
   output logic                misroute_o
);

   logic [CNT_SIZE-1:0] sent_cnt_q, sent_cnt_d;
   logic [CNT_SIZE-1:0] recv_cnt_q, recv_cnt_d;
   logic [CNT_SIZE-1:0] drop_cnt_q, drop_cnt_d;
   logic                misroute_q, misroute_d;

   logic w_tx_pop;
   logic w_rx_xfer;
   logic w_dest_match;
   logic w_rx_accept;

   noc_fifo #(
      .WIDTH (BUS_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) tx_fifo (
      .clk_i     (clk_i),
      .a_rst_n_i (a_rst_n_i),
      .data_i    (pe_data_i),
      .w_i       (pe_w_i),
      .r_o       (pe_r_o),
      .data_o    (net_data_o),
      .w_o       (net_w_o),
      .r_i       (net_r_i)
   );

   assign w_tx_pop = net_w_o & net_r_i;

   // The network side is always drained when there is room; misaddressed
   // flits are consumed but never reach the RX FIFO.
   assign w_dest_match = (`NOC_DEST(net_data_i, BUS_SIZE, ADDR_SIZE) == ADDR_SIZE'(NODE_ID));
   assign w_rx_xfer    = net_w_i & net_r_o;
   assign w_rx_accept  = net_w_i & w_dest_match;

   noc_fifo #(
      .WIDTH (BUS_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) rx_fifo (
      .clk_i     (clk_i),
      .a_rst_n_i (a_rst_n_i),
      .data_i    (net_data_i),
      .w_i       (w_rx_accept),
      .r_o       (net_r_o),
      .data_o    (pe_data_o),
      .w_o       (pe_w_o),
      .r_i       (pe_r_i)
   );

   always_comb begin
      sent_cnt_d = sent_cnt_q;
      recv_cnt_d = recv_cnt_q;
      drop_cnt_d = drop_cnt_q;
      misroute_d = misroute_q;
      if (w_tx_pop) begin
         sent_cnt_d = sent_cnt_q + CNT_SIZE'(1);
      end
      if (w_rx_xfer) begin
         if (w_dest_match) begin
            recv_cnt_d = recv_cnt_q + CNT_SIZE'(1);
         end else begin
            drop_cnt_d = drop_cnt_q + CNT_SIZE'(1);
            misroute_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         sent_cnt_q <= '0;
         recv_cnt_q <= '0;
         drop_cnt_q <= '0;
         misroute_q <= 1'b0;
      end else begin
         sent_cnt_q <= sent_cnt_d;
         recv_cnt_q <= recv_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         misroute_q <= misroute_d;
      end
   end

   assign sent_cnt_o = sent_cnt_q;
   assign recv_cnt_o = recv_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
   assign misroute_o = misroute_q;

endmodule : noc_net_iface

`default_nettype wire

// File: tb/tb_noc_net_iface.sv
// ------------------------------------------------------------------
// tb_noc_net_iface : directed + random bench with queue-based model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_noc_net_iface;

   localparam int BW    = 8;
   localparam int AW    = 4;
   localparam int NID   = 2;
   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [BW-1:0] pe_data_i = '0;
   logic          pe_w_i = 1'b0;
   logic          pe_r_o;
   logic [BW-1:0] pe_data_o;
   logic          pe_w_o;
   logic          pe_r_i = 1'b0;
   logic [BW-1:0] net_data_o;
   logic          net_w_o;
   logic          net_r_i = 1'b0;
   logic [BW-1:0] net_data_i = '0;
   logic          net_w_i = 1'b0;
   logic          net_r_o;
   logic [CW-1:0] sent_cnt_o;
   logic [CW-1:0] recv_cnt_o;
   logic [CW-1:0] drop_cnt_o;
   logic          misroute_o;

   always #5 clk = ~clk;

   noc_net_iface #(
      .BUS_SIZE   (BW),
      .ADDR_SIZE  (AW),
      .NODE_ID    (NID),
      .FIFO_DEPTH (DEPTH),
      .CNT_SIZE   (CW)
   ) dut (
      .clk_i      (clk),
      .a_rst_n_i  (rst_n),
      .pe_data_i  (pe_data_i),
      .pe_w_i     (pe_w_i),
      .pe_r_o     (pe_r_o),
      .pe_data_o  (pe_data_o),
      .pe_w_o     (pe_w_o),
      .pe_r_i     (pe_r_i),
      .net_data_o (net_data_o),
      .net_w_o    (net_w_o),
      .net_r_i    (net_r_i),
      .net_data_i (net_data_i),
      .net_w_i    (net_w_i),
      .net_r_o    (net_r_o),
      .sent_cnt_o (sent_cnt_o),
      .recv_cnt_o (recv_cnt_o),
      .drop_cnt_o (drop_cnt_o),
      .misroute_o (misroute_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: two ordered queues plus traffic counters.
   logic [BW-1:0] m_tx[$];
   logic [BW-1:0] m_rx[$];
   logic [CW-1:0] m_sent, m_recv, m_drop;
   logic          m_mis;

   task automatic model_reset();
      m_tx.delete();
      m_rx.delete();
      m_sent = '0;
      m_recv = '0;
      m_drop = '0;
      m_mis  = 1'b0;
   endtask

   function automatic logic [BW-1:0] exp_net_data();
      return (m_tx.size() > 0) ? m_tx[0] : '0;
   endfunction

   function automatic logic [BW-1:0] exp_pe_data();
      return (m_rx.size() > 0) ? m_rx[0] : '0;
   endfunction

   // Advance one clock; model decisions use the inputs and occupancy seen before the edge.
   task automatic tick();
      bit            tx_push, tx_pop, rx_xfer, rx_pop;
      logic [BW-1:0] d_pe, d_net;
      tx_push = pe_w_i && (m_tx.size() < DEPTH);
      tx_pop  = net_r_i && (m_tx.size() > 0);
      rx_xfer = net_w_i && (m_rx.size() < DEPTH);
      rx_pop  = pe_r_i && (m_rx.size() > 0);
      d_pe    = pe_data_i;
      d_net   = net_data_i;
      @(posedge clk);
      #1;
      if (tx_pop) begin
         void'(m_tx.pop_front());
         m_sent = m_sent + 1'b1;
      end
      if (tx_push) m_tx.push_back(d_pe);
      if (rx_pop) void'(m_rx.pop_front());
      if (rx_xfer) begin
         if (d_net[BW-1 -: AW] == AW'(NID)) begin
            m_rx.push_back(d_net);
            m_recv = m_recv + 1'b1;
         end else begin
            m_drop = m_drop + 1'b1;
            m_mis  = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      pe_w_i     = 1'b0;
      pe_r_i     = 1'b0;
      net_w_i    = 1'b0;
      net_r_i    = 1'b0;
      pe_data_i  = '0;
      net_data_i = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({pe_r_o, net_r_o, net_w_o, pe_w_o, misroute_o} !== 5'b11000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 11000", {pe_r_o, net_r_o, net_w_o, pe_w_o, misroute_o});
      end
      n_checks++;
      if ({sent_cnt_o, recv_cnt_o, drop_cnt_o} !== 48'h0) begin
         n_fail++;
         $display("FAIL reset_counters: got %h expected 0", {sent_cnt_o, recv_cnt_o, drop_cnt_o});
      end
      n_checks++;
      if ({net_data_o, pe_data_o} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {net_data_o, pe_data_o});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_async_reset();
      do_reset();
      net_r_i = 1'b0;
      pe_r_i  = 1'b0;
      pe_w_i  = 1'b1;
      net_w_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         pe_data_i  = BW'($urandom);
         net_data_i = {AW'(NID), 4'(i + 5)};
         tick();
      end
      pe_w_i  = 1'b0;
      net_w_i = 1'b0;
      n_checks++;
      if ({net_w_o, pe_w_o, net_data_o, pe_data_o} !== {1'b1, 1'b1, exp_net_data(), exp_pe_data()}) begin
         n_fail++;
         $display("FAIL async_prefill: got %h expected %h", {net_w_o, pe_w_o, net_data_o, pe_data_o},
                  {1'b1, 1'b1, exp_net_data(), exp_pe_data()});
      end
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({pe_r_o, net_r_o, net_w_o, pe_w_o, net_data_o, pe_data_o} !== {4'b1100, 16'h0}) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", {pe_r_o, net_r_o, net_w_o, pe_w_o, net_data_o, pe_data_o},
                  {4'b1100, 16'h0});
      end
      n_checks++;
      if ({sent_cnt_o, recv_cnt_o, drop_cnt_o, misroute_o} !== 49'h0) begin
         n_fail++;
         $display("FAIL async_reset_cnt: got %h expected 0", {sent_cnt_o, recv_cnt_o, drop_cnt_o, misroute_o});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_tx_latency();
      do_reset();
      net_r_i   = 1'b1;
      pe_w_i    = 1'b1;
      pe_data_i = 8'h3A;
      tick();
      pe_w_i = 1'b0;
      n_checks++;
      if ({net_w_o, net_data_o, sent_cnt_o} !== {1'b1, 8'h3A, 16'd0}) begin
         n_fail++;
         $display("FAIL tx_latency: got %h expected %h", {net_w_o, net_data_o, sent_cnt_o}, {1'b1, 8'h3A, 16'd0});
      end
      tick();
      n_checks++;
      if ({net_w_o, sent_cnt_o} !== {1'b0, 16'd1}) begin
         n_fail++;
         $display("FAIL tx_sent: got %h expected %h", {net_w_o, sent_cnt_o}, {1'b0, 16'd1});
      end
   endtask

   task automatic test_tx_full();
      logic [BW-1:0] exp;
      do_reset();
      net_r_i = 1'b0;
      pe_w_i  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         pe_data_i = BW'(i);
         tick();
         n_checks++;
         if (pe_r_o !== (m_tx.size() < DEPTH)) begin
            n_fail++;
            $display("FAIL tx_full_ready[%0d]: got %b expected %b", i, pe_r_o, (m_tx.size() < DEPTH));
         end
      end
      n_checks++;
      if (pe_r_o !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_full_flag: got %b expected 0", pe_r_o);
      end
      pe_w_i  = 1'b0;
      net_r_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp = BW'(i);
         n_checks++;
         if ({net_w_o, net_data_o} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL tx_order[%0d]: got %h expected %h", i, {net_w_o, net_data_o}, {1'b1, exp});
         end
         tick();
      end
      n_checks++;
      if ({net_w_o, sent_cnt_o} !== {1'b0, 16'd4}) begin
         n_fail++;
         $display("FAIL tx_drain: got %h expected %h", {net_w_o, sent_cnt_o}, {1'b0, 16'd4});
      end
   endtask

   task automatic test_rx_filter();
      do_reset();
      pe_r_i     = 1'b0;
      net_w_i    = 1'b1;
      net_data_i = 8'h25;
      tick();
      net_data_i = 8'h35;
      tick();
      net_w_i = 1'b0;
      n_checks++;
      if ({pe_w_o, pe_data_o, recv_cnt_o, drop_cnt_o, misroute_o} !== {1'b1, 8'h25, 16'd1, 16'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL rx_filter: got %h expected %h", {pe_w_o, pe_data_o, recv_cnt_o, drop_cnt_o, misroute_o},
                  {1'b1, 8'h25, 16'd1, 16'd1, 1'b1});
      end
      pe_r_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if ({misroute_o, pe_w_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL rx_sticky: got %b expected 10", {misroute_o, pe_w_o});
      end
   endtask

   task automatic test_rx_wrap();
      int            sent_idx;
      int            delivered;
      bit            xfer;
      logic [BW-1:0] exp;
      do_reset();
      pe_r_i    = 1'b1;
      sent_idx  = 0;
      delivered = 0;
      for (int c = 0; c < 30; c++) begin
         net_w_i    = (sent_idx < 10);
         net_data_i = {AW'(NID), 4'(sent_idx)};
         n_checks++;
         if (net_r_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_wrap_ready[%0d]: got %b expected 1", c, net_r_o);
         end
         if (pe_w_o === 1'b1) begin
            exp = {AW'(NID), 4'(delivered)};
            n_checks++;
            if (pe_data_o !== exp) begin
               n_fail++;
               $display("FAIL rx_wrap_data[%0d]: got %h expected %h", delivered, pe_data_o, exp);
            end
            delivered++;
         end
         xfer = net_w_i && net_r_o;
         tick();
         if (xfer) sent_idx++;
      end
      net_w_i = 1'b0;
      n_checks++;
      if (delivered != 10 || recv_cnt_o !== 16'd10) begin
         n_fail++;
         $display("FAIL rx_wrap_count: got %0d/%0d expected 10/10", delivered, recv_cnt_o);
      end
   endtask

   task automatic test_concurrency();
      do_reset();
      net_r_i = 1'b0;
      pe_r_i  = 1'b0;
      pe_w_i  = 1'b1;
      net_w_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         pe_data_i  = BW'($urandom);
         net_data_i = {AW'(NID), 4'($urandom)};
         tick();
      end
      net_r_i = 1'b1;
      pe_r_i  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         pe_data_i  = BW'($urandom);
         net_data_i = {AW'(NID), 4'($urandom)};
         tick();
         n_checks++;
         if ({pe_r_o, net_w_o, pe_w_o, net_r_o, net_data_o, pe_data_o} !==
             {4'b1111, exp_net_data(), exp_pe_data()}) begin
            n_fail++;
            $display("FAIL concurrency[%0d]: got %h expected %h", c,
                     {pe_r_o, net_w_o, pe_w_o, net_r_o, net_data_o, pe_data_o},
                     {4'b1111, exp_net_data(), exp_pe_data()});
         end
      end
      n_checks++;
      if ({sent_cnt_o, recv_cnt_o, m_tx.size() == 2, m_rx.size() == 2} !== {16'd20, 16'd22, 2'b11}) begin
         n_fail++;
         $display("FAIL concurrency_cnt: got sent=%0d recv=%0d expected 20/22", sent_cnt_o, recv_cnt_o);
      end
   endtask

   task automatic test_random();
      logic [19:0] exp_io;
      logic [48:0] exp_cnt;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (!(pe_w_i && !pe_r_o)) begin
            pe_w_i    = ($urandom_range(0, 2) != 0);
            pe_data_i = BW'($urandom);
         end
         if (!(net_w_i && !net_r_o)) begin
            net_w_i    = ($urandom_range(0, 2) != 0);
            net_data_i = {($urandom_range(0, 2) == 0) ? AW'($urandom) : AW'(NID), 4'($urandom)};
         end
         net_r_i = ($urandom_range(0, 3) != 0);
         pe_r_i  = ($urandom_range(0, 2) != 0);
         tick();
         exp_io  = {m_tx.size() < DEPTH, m_tx.size() > 0, exp_net_data(),
                    m_rx.size() > 0, exp_pe_data(), m_rx.size() < DEPTH};
         exp_cnt = {m_sent, m_recv, m_drop, m_mis};
         n_checks++;
         if ({pe_r_o, net_w_o, net_data_o, pe_w_o, pe_data_o, net_r_o} !== exp_io) begin
            n_fail++;
            $display("FAIL random_io[%0d]: got %h expected %h", c,
                     {pe_r_o, net_w_o, net_data_o, pe_w_o, pe_data_o, net_r_o}, exp_io);
         end
         n_checks++;
         if ({sent_cnt_o, recv_cnt_o, drop_cnt_o, misroute_o} !== exp_cnt) begin
            n_fail++;
            $display("FAIL random_cnt[%0d]: got %h expected %h", c,
                     {sent_cnt_o, recv_cnt_o, drop_cnt_o, misroute_o}, exp_cnt);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_async_reset();
      test_tx_latency();
      test_tx_full();
      test_rx_filter();
      test_rx_wrap();
      test_concurrency();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_noc_net_iface

`default_nettype wire
